// File: rtl/btn_pkg.sv
// Shared types and constants for the button debounce scheduler.
// Per-button and shared-timer state encodings live here.
package btn_pkg;

  localparam int DELAY_CYCLES_DEFAULT = 40000;
  localparam int N_BTN_MAX = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_REQ = 3'd1,
    PRESS_DLY = 3'd2,
    HELD      = 3'd3,
    REL_REQ   = 3'd4,
    REL_DLY   = 3'd5
  } btn_state_t;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_BUSY = 1'b1
  } tmr_state_t;

  // Round-robin successor of a button index, wrapping at n.
  function automatic logic [2:0] next_idx(
    input logic [2:0] v,
    input int         n
  );
    if (int'(v) + 1 >= n) begin
      return 3'd0;
    end
    return v + 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce_scheduler_if.sv
// Button-side bundle: raw pin levels in, debounced
// pulses/levels and shared-timer status out.
interface btn_debounce_scheduler_if #(
  parameter int N_BTN = 4
);

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] clean;
  logic [N_BTN-1:0] pressed;
  logic             timer_busy;
  logic [2:0]       timer_owner;

  modport master (
    output raw,
    input  clean,
    input  pressed,
    input  timer_busy,
    input  timer_owner
  );

  modport slave (
    input  raw,
    output clean,
    output pressed,
    output timer_busy,
    output timer_owner
  );

endinterface

// File: rtl/shared_delay_timer.sv
// One delay counter shared by all buttons, handed out
// round-robin; expire pulses to the owner on the last count.
module shared_delay_timer
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DELAY_CYCLES = DELAY_CYCLES_DEFAULT
) (
  input  logic             clk5,
  input  logic             reset,
  input  logic [N_BTN-1:0] req,
  output logic [N_BTN-1:0] grant,
  output logic [N_BTN-1:0] expire,
  output logic             busy,
  output logic [2:0]       owner
);

  localparam int CW = $clog2(DELAY_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(DELAY_CYCLES - 1);

  tmr_state_t    state;
  logic [CW-1:0] count;
  logic [2:0]    rr_ptr;
  logic          hit;
  logic [2:0]    pick;

  // First pass looks at or after rr_ptr, second wraps.
  always_comb begin
    hit  = 1'b0;
    pick = 3'd0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!hit && req[i] && 3'(i) >= rr_ptr) begin
        hit  = 1'b1;
        pick = 3'(i);
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (!hit && req[i]) begin
        hit  = 1'b1;
        pick = 3'(i);
      end
    end
  end

  always_comb begin
    grant  = '0;
    expire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      grant[i] = (state == T_IDLE) && hit &&
                 (pick == 3'(i));
      expire[i] = (state == T_BUSY) &&
                  (count == LAST) &&
                  (owner == 3'(i));
    end
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      state  <= T_IDLE;
      count  <= '0;
      rr_ptr <= 3'd0;
      owner  <= 3'd0;
    end else begin
      unique case (state)
        T_IDLE: begin
          if (hit) begin
            owner  <= pick;
            count  <= '0;
            state  <= T_BUSY;
            rr_ptr <= next_idx(pick, N_BTN);
          end
        end
        T_BUSY: begin
          if (count == LAST) begin
            state <= T_IDLE;
          end else begin
            count <= count + CW'(1);
          end
        end
      endcase
    end
  end

  assign busy = (state == T_BUSY);

endmodule

// File: rtl/btn_debounce_scheduler.sv
// Per-button synchronizer + press/release FSM, all sharing
// one delay timer to mask press and release bounce.
module btn_debounce_scheduler
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DELAY_CYCLES = DELAY_CYCLES_DEFAULT
) (
  input logic               clk5,
  input logic               reset,
  btn_debounce_scheduler_if.slave bus
);

  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] expire;
  logic [N_BTN-1:0] clean_v;
  logic [N_BTN-1:0] pressed_v;
  logic             busy_w;
  logic [2:0]       owner_w;

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    logic       s1;
    logic       s;
    logic       cl;
    logic       pr;
    btn_state_t st;

    always_ff @(posedge clk5) begin
      if (reset) begin
        s1 <= 1'b0;
        s  <= 1'b0;
        cl <= 1'b0;
        pr <= 1'b0;
        st <= IDLE;
      end else begin
        s1 <= bus.raw[g];
        s  <= s1;
        cl <= 1'b0;
        unique case (st)
          IDLE: begin
            if (s) begin
              st <= PRESS_REQ;
              cl <= 1'b1;
              pr <= 1'b1;
            end
          end
          PRESS_REQ: begin
            if (grant[g]) st <= PRESS_DLY;
          end
          PRESS_DLY: begin
            if (expire[g]) st <= HELD;
          end
          HELD: begin
            if (!s) st <= REL_REQ;
          end
          REL_REQ: begin
            if (grant[g]) st <= REL_DLY;
          end
          REL_DLY: begin
            if (expire[g]) begin
              st <= IDLE;
              pr <= 1'b0;
            end
          end
          default: begin
            st <= IDLE;
          end
        endcase
      end
    end

    assign req[g] = (st == PRESS_REQ) ||
                    (st == REL_REQ);
    assign clean_v[g]   = cl;
    assign pressed_v[g] = pr;
  end

  shared_delay_timer #(
    .N_BTN        (N_BTN),
    .DELAY_CYCLES (DELAY_CYCLES)
  ) u_timer (
    .clk5   (clk5),
    .reset  (reset),
    .req    (req),
    .grant  (grant),
    .expire (expire),
    .busy   (busy_w),
    .owner  (owner_w)
  );

  assign bus.clean       = clean_v;
  assign bus.pressed     = pressed_v;
  assign bus.timer_busy  = busy_w;
  assign bus.timer_owner = owner_w;

endmodule

// File: tb/tb_btn_debounce_scheduler.sv
// Directed bench for btn_debounce_scheduler: two instances
// (4 buttons / 16-cycle delay, 1 button / 2-cycle delay).
module tb_btn_debounce_scheduler;

  localparam int NA = 4;
  localparam int DA = 16;
  localparam int NB = 1;
  localparam int DB = 2;

  typedef struct packed {
    logic [3:0] val;
    int         cyc;
  } clean_ev_t;

  typedef struct packed {
    logic [2:0] owner;
    int         start;
    int         len;
  } grant_ev_t;

  logic clk5 = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c, r, p, q;

  clean_ev_t clean_exp[$];
  clean_ev_t clean_obs[$];
  clean_ev_t cleanb_exp[$];
  clean_ev_t cleanb_obs[$];
  grant_ev_t grant_exp[$];
  grant_ev_t grant_obs[$];

  btn_debounce_scheduler_if #(.N_BTN(NA)) bus_a ();
  btn_debounce_scheduler_if #(.N_BTN(NB)) bus_b ();

  btn_debounce_scheduler #(
    .N_BTN        (NA),
    .DELAY_CYCLES (DA)
  ) dut_a (
    .clk5  (clk5),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  btn_debounce_scheduler #(
    .N_BTN        (NB),
    .DELAY_CYCLES (DB)
  ) dut_b (
    .clk5  (clk5),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #100 clk5 = ~clk5;

  initial begin
    forever begin
      @(posedge clk5);
      cyc++;
    end
  end

  // Observed-event recorder sampled on the falling edge.
  initial begin
    logic       busy_d;
    logic [2:0] g_own;
    int         g_start;
    busy_d  = 1'b0;
    g_own   = 3'd0;
    g_start = 0;
    forever begin
      @(negedge clk5);
      if (|bus_a.clean)
        clean_obs.push_back('{val: bus_a.clean, cyc: cyc});
      if (bus_b.clean[0] === 1'b1)
        cleanb_obs.push_back('{val: 4'b0001, cyc: cyc});
      if (bus_a.timer_busy === 1'b1 && !busy_d) begin
        g_own   = bus_a.timer_owner;
        g_start = cyc;
      end
      if (bus_a.timer_busy === 1'b0 && busy_d)
        grant_obs.push_back('{owner: g_own,
                              start: g_start,
                              len: cyc - g_start});
      busy_d = (bus_a.timer_busy === 1'b1);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk5);
  endtask

  task automatic exp_clean(input logic [3:0] v,
                           input int t);
    clean_exp.push_back('{val: v, cyc: t});
  endtask

  task automatic exp_grant(input logic [2:0] o,
                           input int t,
                           input int len = DA);
    grant_exp.push_back('{owner: o, start: t, len: len});
  endtask

  task automatic drain();
    clean_ev_t ce, co;
    grant_ev_t ge, go;
    int t;
    while (clean_exp.size() > 0) begin
      ce = clean_exp.pop_front();
      t = 0;
      while (clean_obs.size() == 0 && t < 200) begin
        @(negedge clk5);
        t++;
      end
      if (clean_obs.size() > 0) co = clean_obs.pop_front();
      else co = '{val: 4'hf, cyc: -1};
      checks++;
      assert (co === ce) else begin
        errors++;
        $error("FAIL clean_a: observed %b@%0d expected %b@%0d",
               co.val, co.cyc, ce.val, ce.cyc);
      end
    end
    while (grant_exp.size() > 0) begin
      ge = grant_exp.pop_front();
      t = 0;
      while (grant_obs.size() == 0 && t < 200) begin
        @(negedge clk5);
        t++;
      end
      if (grant_obs.size() > 0) go = grant_obs.pop_front();
      else go = '{owner: 3'd7, start: -1, len: -1};
      checks++;
      assert (go === ge) else begin
        errors++;
        $error("FAIL grant: observed own %0d start %0d len %0d expected own %0d start %0d len %0d",
               go.owner, go.start, go.len,
               ge.owner, ge.start, ge.len);
      end
    end
    while (cleanb_exp.size() > 0) begin
      ce = cleanb_exp.pop_front();
      t = 0;
      while (cleanb_obs.size() == 0 && t < 200) begin
        @(negedge clk5);
        t++;
      end
      if (cleanb_obs.size() > 0) co = cleanb_obs.pop_front();
      else co = '{val: 4'hf, cyc: -1};
      checks++;
      assert (co === ce) else begin
        errors++;
        $error("FAIL clean_b: observed %b@%0d expected %b@%0d",
               co.val, co.cyc, ce.val, ce.cyc);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_a.raw = '0;
    bus_b.raw = '0;
    repeat (3) @(negedge clk5);
    chk("rst_clean", 32'(bus_a.clean), 0);
    chk("rst_pressed", 32'(bus_a.pressed), 0);
    chk("rst_busy", 32'(bus_a.timer_busy), 0);
    chk("rst_owner", 32'(bus_a.timer_owner), 0);
    chk("rst_b_clean", 32'(bus_b.clean), 0);
    chk("rst_b_pressed", 32'(bus_b.pressed), 0);
    reset = 1'b0;

    // single press on button 0
    c = cyc + 2;
    wait_cyc(c);
    bus_a.raw[0] = 1'b1;
    exp_clean(4'b0001, c + 3);
    exp_grant(3'd0, c + 4);
    wait_cyc(c + 2);
    chk("p0_early", 32'(bus_a.clean), 0);
    wait_cyc(c + 3);
    chk("p0_clean", 32'(bus_a.clean), 32'b0001);
    chk("p0_pressed", 32'(bus_a.pressed), 32'b0001);
    wait_cyc(c + 4);
    chk("p0_pulse_end", 32'(bus_a.clean), 0);
    r = c + 100;
    wait_cyc(r);
    bus_a.raw[0] = 1'b0;
    exp_grant(3'd0, r + 4);
    wait_cyc(r + 19);
    chk("p0_hold", 32'(bus_a.pressed), 32'b0001);
    wait_cyc(r + 20);
    chk("p0_release", 32'(bus_a.pressed), 0);
    drain();

    // bouncing button 1
    c = cyc + 2;
    wait_cyc(c);
    bus_a.raw[1] = 1'b1;
    exp_clean(4'b0010, c + 3);
    exp_grant(3'd1, c + 4);
    wait_cyc(c + 3);
    bus_a.raw[1] = 1'b0;
    wait_cyc(c + 6);
    bus_a.raw[1] = 1'b1;
    wait_cyc(c + 9);
    bus_a.raw[1] = 1'b0;
    wait_cyc(c + 12);
    bus_a.raw[1] = 1'b1;
    r = c + 40;
    wait_cyc(r);
    bus_a.raw[1] = 1'b0;
    exp_grant(3'd1, r + 4);
    wait_cyc(r + 20);
    chk("b1_release", 32'(bus_a.pressed), 0);
    p = r + 30;
    wait_cyc(p);
    bus_a.raw[1] = 1'b1;
    exp_clean(4'b0010, p + 3);
    exp_grant(3'd1, p + 4);
    q = p + 40;
    wait_cyc(q);
    bus_a.raw[1] = 1'b0;
    exp_grant(3'd1, q + 4);
    wait_cyc(q + 24);
    drain();

    // reset in the middle of a press delay
    c = cyc + 2;
    wait_cyc(c);
    bus_a.raw[3] = 1'b1;
    exp_clean(4'b1000, c + 3);
    exp_grant(3'd3, c + 4, 7);
    wait_cyc(c + 10);
    reset = 1'b1;
    wait_cyc(c + 11);
    chk("mid_rst_clean", 32'(bus_a.clean), 0);
    chk("mid_rst_pressed", 32'(bus_a.pressed), 0);
    chk("mid_rst_busy", 32'(bus_a.timer_busy), 0);
    chk("mid_rst_owner", 32'(bus_a.timer_owner), 0);
    reset = 1'b0;
    wait_cyc(c + 13);
    chk("mid_rst_quiet", 32'(bus_a.pressed), 0);
    exp_clean(4'b1000, c + 14);
    exp_grant(3'd3, c + 15);
    wait_cyc(c + 14);
    chk("mid_rst_fresh", 32'(bus_a.clean), 32'b1000);
    r = c + 50;
    wait_cyc(r);
    bus_a.raw[3] = 1'b0;
    exp_grant(3'd3, r + 4);
    wait_cyc(r + 24);
    drain();

    // simultaneous 0 and 2, then all four for fairness
    c = cyc + 2;
    wait_cyc(c);
    bus_a.raw = 4'b0101;
    exp_clean(4'b0101, c + 3);
    exp_grant(3'd0, c + 4);
    exp_grant(3'd2, c + 21);
    wait_cyc(c + 20);
    chk("sim_owner0", 32'(bus_a.timer_owner), 0);
    wait_cyc(c + 21);
    chk("sim_owner2", 32'(bus_a.timer_owner), 2);
    r = c + 60;
    wait_cyc(r);
    bus_a.raw = 4'b0000;
    exp_grant(3'd0, r + 4);
    exp_grant(3'd2, r + 21);
    p = r + 60;
    wait_cyc(p);
    bus_a.raw = 4'b1111;
    exp_clean(4'b1111, p + 3);
    for (int k = 0; k < 4; k++)
      exp_grant(3'((3 + k) % 4), p + 4 + 17 * k);
    q = p + 80;
    wait_cyc(q);
    bus_a.raw = 4'b0000;
    for (int k = 0; k < 4; k++)
      exp_grant(3'((3 + k) % 4), q + 4 + 17 * k);
    wait_cyc(q + 80);
    chk("rr_all_released", 32'(bus_a.pressed), 0);
    drain();

    // fastest legal press rate on the 2-cycle instance
    c = cyc + 2;
    for (int k = 0; k < 5; k++) begin
      wait_cyc(c + 8 * k);
      bus_b.raw[0] = 1'b1;
      cleanb_exp.push_back('{val: 4'b0001,
                             cyc: c + 8 * k + 3});
      wait_cyc(c + 8 * k + 4);
      bus_b.raw[0] = 1'b0;
    end
    wait_cyc(c + 50);
    chk("fast_idle", 32'(bus_b.pressed), 0);
    drain();

    // all four held permanently after a fresh reset
    @(negedge clk5);
    reset = 1'b1;
    @(negedge clk5);
    reset = 1'b0;
    c = cyc + 2;
    wait_cyc(c);
    bus_a.raw = 4'b1111;
    exp_clean(4'b1111, c + 3);
    for (int k = 0; k < 4; k++)
      exp_grant(3'(k), c + 4 + 17 * k);
    wait_cyc(c + 80);
    chk("all_pressed", 32'(bus_a.pressed), 32'b1111);
    chk("all_idle", 32'(bus_a.timer_busy), 0);
    chk("all_owner", 32'(bus_a.timer_owner), 3);
    drain();

    chk("extra_clean_a", 32'(clean_obs.size()), 0);
    chk("extra_clean_b", 32'(cleanb_obs.size()), 0);
    chk("extra_grant", 32'(grant_obs.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_scheduler.md
# btn_debounce_scheduler

Debounces N_BTN raw push-button inputs using a single shared delay timer rather than one counter per button. Each button has its own small FSM that emits a one-cycle `clean` pulse per accepted press, then requests the shared timer to mask press bounce and release bounce. A round-robin arbiter hands the timer to one requester at a time. The block sits between the board button pins and the user-logic FSMs, all in the clk5 (5 MHz) domain.

## Interface
- `N_BTN`, 4: number of buttons, 1..8.
- `DELAY_CYCLES`, 40000: debounce mask length in clk5 cycles (8 ms at 5 MHz), must be ≥ 2.
- `clk5`  in  1  system clock, 5 MHz.
- `reset`  in  1  synchronous, active-high.
- `raw`  in  N_BTN  asynchronous button levels, active-high.
- `clean`  out  N_BTN  one-cycle press pulse per button.
- `pressed`  out  N_BTN  debounced level: high from press detect until the release delay completes.
- `timer_busy`  out  1  shared timer is counting.
- `timer_owner`  out  3  index of the current timer grant; holds its last value when idle.

## Operation
- Each `raw[i]` passes through a 2-flop synchronizer. Only the second flop (`s[i]`) feeds the logic.
- Per-button FSM states:
  - `IDLE`: if `s[i]`=1, go to `PRESS_REQ`, assert `clean[i]` for one cycle, and set `pressed[i]`.
  - `PRESS_REQ`: `req[i]`=1; on grant go to `PRESS_DLY`.
  - `PRESS_DLY`: wait for `expire[i]`, then go to `HELD`.
  - `HELD`: if `s[i]`=0, go to `REL_REQ`.
  - `REL_REQ`: `req[i]`=1; on grant go to `REL_DLY`.
  - `REL_DLY`: on `expire[i]`, go to `IDLE` and clear `pressed[i]`.
- `s[i]` is ignored in every `*_REQ` and `*_DLY` state. Bounce during queueing is masked.
- Unused state encodings go to `IDLE` with `clean`=0.
- Arbiter states:
  - `T_IDLE`: if any `req` is set, pick the first requester at or after `rr_ptr` (wrapping modulo N_BTN). Register it as `timer_owner`, clear the count, go to `T_BUSY`, and set `rr_ptr` = owner+1 (mod N_BTN).
  - `T_BUSY`: the count increments each cycle. At count == DELAY_CYCLES−1, pulse `expire[owner]` for one cycle and return to `T_IDLE`.
- The counter is `$clog2(DELAY_CYCLES)` bits wide and never wraps, because it is cleared on grant.
- Presses on different buttons are independent. Simultaneous presses produce `clean` pulses in the same cycle; timer service for those buttons is then serialized.
- Reset values: all FSMs `IDLE`, arbiter `T_IDLE`, count 0, `rr_ptr` 0, synchronizers 0, `clean`/`pressed`/`timer_busy` = 0, `timer_owner` = 0.
- Reset mid-delay aborts the delay with no `expire` and no pulse.

## Timing
- Press latency: `clean[i]` is high during the cycle after the 3rd rising clk5 edge following `raw[i]` rising (2 synchronizer edges plus 1 FSM edge). The pulse is exactly 1 cycle.
- Grant latency: `req` is seen in `T_IDLE` at edge k; `timer_busy`=1 from edge k+1. The grant state change in the FSM is in the same edge.
- Timer occupancy is DELAY_CYCLES cycles in `T_BUSY`, followed by at least 1 cycle in `T_IDLE` before the next grant.
- Worst-case wait for the timer is (N_BTN−1)·(DELAY_CYCLES+1) cycles. The `clean` pulse is not delayed by this wait.
- A new press on button i is accepted no earlier than 2·DELAY_CYCLES+4 cycles after the previous press detect.

## Structure
- Shared package `btn_pkg`:
  - per-button FSM state enum (3-bit).
  - arbiter state enum (1-bit).
  - `DELAY_CYCLES_DEFAULT` = 40000.
  - `N_BTN_MAX` = 8.
- Sub-module `shared_delay_timer`: owns the round-robin arbiter, the counter and the `expire` decode.
  - Inputs: `req[N_BTN]`.
  - Outputs: `grant[N_BTN]` (one-hot, one-cycle at grant), `expire[N_BTN]`, `busy`, `owner`.
- The top level generates N_BTN synchronizer+FSM instances.

## Test plan
- Single press, DELAY_CYCLES=16: `raw[0]` high for 100 cycles.
  - `clean[0]` is a 1-cycle pulse at edge 3 and `pressed[0]` rises with it.
  - `timer_busy` is high 16 cycles, twice.
  - `pressed[0]` falls 16+1 cycles after `raw[0]` falls plus synchronizer delay.
- Bounce: `raw[1]` toggles every 3 cycles for 12 cycles, then holds high.
  - Exactly one `clean[1]` pulse.
  - A second pulse only after release and delay complete.
- Simultaneous press of `raw[0]` and `raw[2]`.
  - Both `clean` pulses occur in the same cycle.
  - `timer_owner` is 0 and then 2.
  - `rr_ptr` fairness: after the next all-button press, the order starts at 3.
- Reset asserted mid-`PRESS_DLY`.
  - All outputs 0 in the following cycle.
  - No `expire`; holding raw after reset yields a fresh `clean` pulse.
- Boundary DELAY_CYCLES=2 with N_BTN=1: press/release at the fastest legal rate, giving one pulse per press with no missed or duplicate pulses.
- All four buttons held permanently.
  - 4 pulses in one cycle.
  - The timer is granted 0,1,2,3 with a 1-cycle idle gap each.
  - Then idle, with `pressed`=1111.
